// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. It processes one bit per clock,
// LSB first, through a single full_adder cell. The carry is held in a flop
// and fed back into the cell's carry input.
//
// The file also holds full_adder, the one-bit cell the serial datapath is
// built around, so that the design stays self-contained.
//
// full_adder ports:
//   a, b, cin   one-bit addends and carry-in
//   s, co       one-bit sum and carry-out (purely combinational)
//
// serial_adder ports:
//   clk         system clock; all state updates happen on the rising edge
//   rst_n       synchronous active-low reset
//   start       request to begin an addition; honoured only while idle
//   A, B, Cin   operands and carry-in, captured on the accepting edge
//   busy        high while the addition is in progress
//   done        one-cycle pulse; Sum/Cout have just been updated
//   Sum         registered result (A + B + Cin) mod 2^WIDTH
//   Cout        registered carry-out of bit WIDTH-1
//
// Timing: the start request is accepted at edge 0. busy is high for WIDTH
// cycles, and done is high for the cycle after that. The block then spends
// one cycle in idle, so one addition completes every WIDTH+2 cycles.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ cin;
        co = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    // One extra bit so that the counter can hold WIDTH-1 for every legal width.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  s_sh_q, s_sh_d;
    logic              c_q, c_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              fa_s;
    logic              fa_co;
    logic              last_bit;

    // The cell always sees the current LSBs. Its outputs are only used in the
    // run state.
    full_adder u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (c_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    c_d     = Cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                // Shift the new sum bit in at the top. After WIDTH shifts,
                // bit 0 of the result has reached the LSB.
                s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                c_d    = fa_co;
                cnt_d  = cnt_q + CntW'(1);
                if (last_bit) begin
                    // The outputs are updated only here, so a consumer never
                    // sees a partial sum.
                    sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // busy and done are decoded directly from the state register.
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder. It runs an 8-bit and a 4-bit instance side by
// side. A cycle-level model built from the block's timing rules and plain
// integer addition is compared against both instances on every cycle. Directed
// vectors carry hand-computed literal expectations.

module tb_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st8, ci8, st4, ci4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       busy8, done8, co8;
    logic [7:0] s8;
    logic       busy4, done4, co4;
    logic [3:0] s4;

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (st8),
        .A     (a8),
        .B     (b8),
        .Cin   (ci8),
        .busy  (busy8),
        .done  (done8),
        .Sum   (s8),
        .Cout  (co8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (st4),
        .A     (a4),
        .B     (b4),
        .Cin   (ci4),
        .busy  (busy4),
        .done  (done4),
        .Sum   (s4),
        .Cout  (co4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model. ph = -1 means idle. Otherwise ph counts the edges since the
    // acceptance edge: phases 0..W-1 are busy and phase W is the done cycle.
    // res holds the latest {Cout, Sum} as an integer.
    int  m_ph[2]   = '{-1, -1};
    int  m_pend[2] = '{0, 0};
    int  m_res[2]  = '{0, 0};
    bit  started   = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int  w;
            bit  st;
            int  sum;
            w   = (k == 0) ? 8 : 4;
            st  = (k == 0) ? st8 : st4;
            sum = (k == 0) ? int'(a8) + int'(b8) + int'(ci8)
                           : int'(a4) + int'(b4) + int'(ci4);
            if (!rst_n) begin
                m_ph[k]  = -1;
                m_res[k] = 0;
            end else if (m_ph[k] < 0) begin
                if (st) begin
                    m_ph[k]   = 0;
                    m_pend[k] = sum;
                end
            end else if (m_ph[k] == w) begin
                m_ph[k] = -1;
            end else begin
                m_ph[k] = m_ph[k] + 1;
                if (m_ph[k] == w) m_res[k] = m_pend[k];
            end
        end
    end

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            logic [10:0] e8;
            logic [6:0]  e4;
            e8 = {(m_ph[0] >= 0 && m_ph[0] < 8), (m_ph[0] == 8), m_res[0][8], m_res[0][7:0]};
            e4 = {(m_ph[1] >= 0 && m_ph[1] < 4), (m_ph[1] == 4), m_res[1][4], m_res[1][3:0]};
            chk("cyc8 {busy,done,cout,sum}", 64'({busy8, done8, co8, s8}), 64'(e8));
            chk("cyc4 {busy,done,cout,sum}", 64'({busy4, done4, co4, s4}), 64'(e4));
        end
    end

    // Pulse start for one cycle. On return we are at the negedge of the
    // first RUN cycle, which is cycle 1 after acceptance.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        st8 = 1'b1; a8 = a; b8 = b; ci8 = c;
        @(negedge clk);
        st8 = 1'b0;
    endtask

    // Wait for done. The argument n0 is the index of the current cycle. The
    // task returns the index of the done cycle, or -1 if the wait times out.
    task automatic wait8(input int n0, output int n);
        n = n0;
        while (!done8 && n < n0 + 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) begin
            chk("wait8 timeout", 64'(0), 64'(1));
            n = -1;
        end
    endtask

    task automatic count_done8(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t t2[3] = '{
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
        '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0}
    };

    vec_t t5[4] = '{
        '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
        '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0},
        '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1}
    };

    initial begin
        int n;
        int p;
        int last;
        rst_n = 1'b0;
        st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        st4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy8), 64'(0));
        chk("reset done", 64'(done8), 64'(0));
        chk("reset sum",  64'(s8), 64'(0));
        chk("reset cout", 64'(co8), 64'(0));
        rst_n = 1'b1;

        // Test 1: basic addition and latency.
        go8(8'h3C, 8'h5A, 1'b0);
        wait8(1, n);
        chk("t1 done cycle", 64'(n), 64'(9));
        chk("t1 sum", 64'(s8), 64'(8'h96));
        chk("t1 cout", 64'(co8), 64'(0));

        // Test 2: carry and wrap corner cases.
        for (int i = 0; i < 3; i++) begin
            go8(t2[i].a, t2[i].b, t2[i].c);
            wait8(1, n);
            chk("t2 sum", 64'(s8), 64'(t2[i].s));
            chk("t2 cout", 64'(co8), 64'(t2[i].co));
        end

        // Test 3: a start request during RUN is ignored.
        go8(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        @(negedge clk);
        st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        st8 = 1'b0;
        wait8(4, n);
        chk("t3 done cycle", 64'(n), 64'(9));
        chk("t3 sum", 64'(s8), 64'(8'h46));
        chk("t3 cout", 64'(co8), 64'(0));
        count_done8(12, p);
        chk("t3 extra done pulses", 64'(p), 64'(0));

        // Test 4: a reset during RUN aborts the addition.
        go8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4 busy after abort", 64'(busy8), 64'(0));
        chk("t4 sum after abort", 64'(s8), 64'(0));
        chk("t4 cout after abort", 64'(co8), 64'(0));
        count_done8(15, p);
        chk("t4 done pulses after abort", 64'(p), 64'(0));
        go8(8'hAA, 8'h55, 1'b0);
        wait8(1, n);
        chk("t4 sum", 64'(s8), 64'(8'hFF));
        chk("t4 cout", 64'(co8), 64'(0));

        // Test 5: start held high gives back-to-back additions.
        @(negedge clk);
        st8 = 1'b1; a8 = t5[0].a; b8 = t5[0].b; ci8 = t5[0].c;
        n = 0;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            int guard;
            guard = 0;
            do begin
                @(negedge clk);
                n++;
                guard++;
            end while (!done8 && guard < 30);
            chk("t5 done seen", 64'(done8), 64'(1));
            chk("t5 sum", 64'(s8), 64'(t5[i].s));
            chk("t5 cout", 64'(co8), 64'(t5[i].co));
            if (i > 0) chk("t5 done spacing", 64'(n - last), 64'(10));
            last = n;
            if (i < 3) begin
                a8 = t5[i+1].a; b8 = t5[i+1].b; ci8 = t5[i+1].c;
            end else begin
                st8 = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // Test 6: exhaustive sweep of the 4-bit instance.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int g;
                    int exp;
                    @(negedge clk);
                    st4 = 1'b1; a4 = 4'(a); b4 = 4'(b); ci4 = c[0];
                    @(negedge clk);
                    st4 = 1'b0;
                    g = 0;
                    while (!done4 && g < 20) begin
                        @(negedge clk);
                        g++;
                    end
                    exp = a + b + c;
                    chk("t6 {cout,sum}", 64'({co4, s4}), 64'(exp[4:0]));
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
